// File: rtl/pio_in_pkg.sv
// pio_in_pkg: register offsets and edge-mode encoding shared by the
// debounced input PIO (optional debouncer enabled by PIO_IN_DEBOUNCE_EN).
package pio_in_pkg;

  localparam logic [1:0] PIO_REG_DATA     = 2'd0;
  localparam logic [1:0] PIO_REG_IRQMASK  = 2'd1;
  localparam logic [1:0] PIO_REG_EDGECAP  = 2'd2;
  localparam logic [1:0] PIO_REG_EDGEMODE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one input bit, 2-flop synchroniser plus optional
// stable-count debouncer (built only with PIO_IN_DEBOUNCE_EN).
module pio_debounce
  import pio_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  logic [1:0] sync;

  // bring the raw pin into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], din};
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stable_q;

  // accept a new level only after it has held long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sync[1] == stable_q) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      stable_q <= sync[1];
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync[1];
`endif

endmodule

// File: rtl/pio_in_debounced.sv
// pio_in_debounced: Avalon-MM input PIO with edge capture and masked irq;
// per-bit debouncing is compiled in when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_debounced
  import pio_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pio_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_dc
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  edge_mode_t       edge_mode;
  logic [31:0]      rdata;
  logic             sel_data;
  logic             sel_mask;
  logic             sel_cap;
  logic             sel_mode;
  logic             unused;

  assign unused = ^avs_writedata;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (pio_in[g]),
      .stable(stable[g])
    );
  end

  assign sel_data = (avs_address == PIO_REG_DATA);
  assign sel_mask = (avs_address == PIO_REG_IRQMASK);
  assign sel_cap  = (avs_address == PIO_REG_EDGECAP);
  assign sel_mode = (avs_address == PIO_REG_EDGEMODE);

  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;

  assign cap_clr = (avs_write && sel_cap) ?
                   avs_writedata[WIDTH-1:0] : '0;

  // qualify edges against the selected mode
  always_comb begin
    edge_set = '0;
    unique case (edge_mode)
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      EDGE_BOTH: edge_set = rise | fall;
      EDGE_NONE: edge_set = '0;
      default:   edge_set = '0;
    endcase
  end

  // previous stable level, for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable;
    end
  end

  // capture edges; a new edge beats a same-cycle clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_set;
    end
  end

  // software-writable control registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask  <= '0;
      edge_mode <= EDGE_RISE;
    end else if (avs_write) begin
      if (sel_mask) irq_mask <= avs_writedata[WIDTH-1:0];
      if (sel_mode) edge_mode <= edge_mode_t'(avs_writedata[1:0]);
    end
  end

  // read mux, unimplemented bits zero
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_data: rdata = 32'(stable);
      sel_mask: rdata = 32'(irq_mask);
      sel_cap:  rdata = 32'(edge_cap);
      sel_mode: rdata = 32'(edge_mode);
      default:  rdata = '0;
    endcase
  end

  // one-cycle registered read response
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rdata;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_debounced.sv
// tb_pio_in_debounced: directed and random checks of the input PIO
// against a behavioural model (latencies follow PIO_IN_DEBOUNCE_EN).
module tb_pio_in_debounced;
  import pio_in_pkg::*;

  localparam int W  = 18;
  localparam int DC = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  pio_in = '0;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pio_in_debounced #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .pio_in       (pio_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  // behavioural model: pin seen two clocks late, a new level is
  // accepted after DC consecutive differing samples, edges captured
  logic [W-1:0] m_p1, m_p2, m_stb, m_prev, m_cap, m_mask;
  logic [W-1:0] m_set, m_clr, m_nstb;
  logic [1:0]   m_mode;
  logic [31:0]  m_rd;
  int           m_run [W];
  logic         m_irq;

  assign m_irq = |(m_cap & m_mask);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '0; m_p2 = '0; m_stb = '0; m_prev = '0;
      m_cap = '0; m_mask = '0; m_mode = '0; m_rd = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      if (avs_read) begin
        case (avs_address)
          2'd0:    m_rd = 32'(m_stb);
          2'd1:    m_rd = 32'(m_mask);
          2'd2:    m_rd = 32'(m_cap);
          default: m_rd = 32'(m_mode);
        endcase
      end
      case (m_mode)
        2'd0:    m_set = m_stb & ~m_prev;
        2'd1:    m_set = ~m_stb & m_prev;
        2'd2:    m_set = m_stb ^ m_prev;
        default: m_set = '0;
      endcase
      m_clr = (avs_write && avs_address == 2'd2) ?
              avs_writedata[W-1:0] : '0;
      m_cap = (m_cap & ~m_clr) | m_set;
      if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[W-1:0];
      if (avs_write && avs_address == 2'd3) m_mode = avs_writedata[1:0];
      m_nstb = m_stb;
`ifdef PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
        if (m_p2[b] != m_stb[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_nstb[b] = m_p2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
`else
      m_nstb = m_p1;
`endif
      m_prev = m_stb;
      m_stb  = m_nstb;
      m_p2   = m_p1;
      m_p1   = pio_in;
    end
  end

  // bus helpers: called and return at a falling edge
  task automatic do_read(input logic [1:0] a,
                         output logic [31:0] got,
                         output logic [31:0] exp);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    got = avs_readdata;
    exp = m_rd;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
    do_write(PIO_REG_EDGECAP, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset();
    logic [31:0] g, e;
    rst_n = 1'b0;
    pio_in = 18'h3FFFF;
    repeat (3) @(negedge clk);
    n_chk++;
    if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%h irq=%b need 0/0",
               avs_readdata, irq);
    end
    rst_n = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g !== 32'h0 || g !== e) begin
      n_fail++;
      $display("FAIL reset_data_early: got %h need 0 (model %h)", g, e);
    end
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g !== 32'h3FFFF || g !== e) begin
      n_fail++;
      $display("FAIL reset_data_late: got %h need 3ffff (model %h)", g, e);
    end
    do_read(PIO_REG_IRQMASK, g, e);
    n_chk++;
    if (g !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_irqmask: got %h need 0", g);
    end
    do_read(PIO_REG_EDGEMODE, g, e);
    n_chk++;
    if (g !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_edgemode: got %h need 0", g);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] g, e;
    pio_in = '0;
    settle();
    do_write(PIO_REG_EDGEMODE, 32'h0);
    do_write(PIO_REG_IRQMASK, 32'h8);
    do_write(PIO_REG_EDGECAP, 32'hFFFF_FFFF);
    pio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    pio_in[3] = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (irq !== m_irq) begin
        n_fail++;
        $display("FAIL glitch_irq: cycle %0d got %b need %b", i, irq, m_irq);
      end
`ifdef PIO_IN_DEBOUNCE_EN
      n_chk++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_irq_low: cycle %0d got %b need 0", i, irq);
      end
`endif
    end
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL glitch_data: got %h need %h", g, e);
    end
    do_read(PIO_REG_EDGECAP, g, e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL glitch_edgecap: got %h need %h", g, e);
    end
`ifdef PIO_IN_DEBOUNCE_EN
    n_chk++;
    if (g !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_edgecap_zero: got %h need 0", g);
    end
`endif
  endtask

  task automatic test_rise_irq();
    logic exp;
    settle();
    do_write(PIO_REG_EDGEMODE, 32'h0);
    do_write(PIO_REG_IRQMASK, 32'h8);
    pio_in[3] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      exp = (k >= LAT + 1);
      n_chk++;
      if (irq !== exp || irq !== m_irq) begin
        n_fail++;
        $display("FAIL rise_irq: clock %0d got %b need %b", k, irq, exp);
      end
    end
    do_write(PIO_REG_EDGECAP, 32'h8);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_irq_clear: got %b need 0", irq);
    end
  endtask

  task automatic test_both_fall();
    logic [31:0] g, e;
    do_write(PIO_REG_IRQMASK, 32'h0);
    do_write(PIO_REG_EDGEMODE, 32'h2);
    pio_in[0] = 1'b1;
    settle();
    pio_in[0] = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_irq_masked: cycle %0d got %b need 0", i, irq);
      end
    end
    do_read(PIO_REG_EDGECAP, g, e);
    n_chk++;
    if (g !== 32'h1 || g !== e) begin
      n_fail++;
      $display("FAIL fall_edgecap: got %h need 1 (model %h)", g, e);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] g, e;
    do_write(PIO_REG_EDGEMODE, 32'h2);
    settle();
    pio_in[5] = ~pio_in[5];
    repeat (LAT) @(negedge clk);
    do_write(PIO_REG_EDGECAP, 32'h20);
    do_read(PIO_REG_EDGECAP, g, e);
    n_chk++;
    if (g !== 32'h20 || g !== e) begin
      n_fail++;
      $display("FAIL set_wins: got %h need 20 (model %h)", g, e);
    end
  endtask

  task automatic test_regs();
    logic [31:0] g, e;
    do_write(PIO_REG_IRQMASK, 32'hFFFF_FFFF);
    do_read(PIO_REG_IRQMASK, g, e);
    n_chk++;
    if (g !== 32'h3FFFF) begin
      n_fail++;
      $display("FAIL irqmask_width: got %h need 3ffff", g);
    end
    do_write(PIO_REG_EDGEMODE, 32'hFFFF_FFFF);
    do_read(PIO_REG_EDGEMODE, g, e);
    n_chk++;
    if (g !== 32'h3) begin
      n_fail++;
      $display("FAIL edgemode_width: got %h need 3", g);
    end
    do_write(PIO_REG_DATA, 32'hFFFF_FFFF);
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL data_ro: got %h need %h", g, e);
    end
    do_read(PIO_REG_EDGECAP, g, e);
    n_chk++;
    if (g !== 32'h20 || g !== e) begin
      n_fail++;
      $display("FAIL mode_keeps_cap: got %h need 20 (model %h)", g, e);
    end
    do_write(PIO_REG_IRQMASK, 32'h0);
  endtask

  task automatic test_step_latency();
    logic [31:0] g, e;
    do_write(PIO_REG_EDGEMODE, 32'h0);
    do_write(PIO_REG_IRQMASK, 32'h20000);
    settle();
    pio_in[17] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g[17] !== 1'b0 || irq !== 1'b0 || g !== e) begin
      n_fail++;
      $display("FAIL step_early: got d=%h irq=%b need bit17=0 irq=0",
               g, irq);
    end
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g[17] !== 1'b1 || irq !== 1'b1 || g !== e) begin
      n_fail++;
      $display("FAIL step_data: got d=%h irq=%b need bit17=1 irq=1",
               g, irq);
    end
    do_read(PIO_REG_EDGECAP, g, e);
    n_chk++;
    if (g !== 32'h20000 || g !== e) begin
      n_fail++;
      $display("FAIL step_edgecap: got %h need 20000 (model %h)", g, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e;
    pio_in = ~pio_in;
    repeat (3) @(negedge clk);
    avs_address = PIO_REG_DATA;
    avs_read = 1'b1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got rd=%h irq=%b need 0/0",
               avs_readdata, irq);
    end
    @(negedge clk);
    avs_read = 1'b0;
    n_chk++;
    if (avs_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_noresp: got %h need 0", avs_readdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_read(PIO_REG_DATA, g, e);
    n_chk++;
    if (g !== 32'h0 || g !== e) begin
      n_fail++;
      $display("FAIL reset_mid_data: got %h need 0 (model %h)", g, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] g, e;
    int op;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0)
        pio_in = pio_in ^ W'($urandom);
      op = $urandom_range(0, 3);
      if (op == 1) begin
        do_read(2'($urandom), g, e);
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL rand_read: iter %0d addr %0d got %h need %h",
                   i, avs_address, g, e);
        end
      end else if (op == 2) begin
        do_write(2'($urandom), $urandom);
      end else begin
        @(negedge clk);
      end
      n_chk++;
      if (irq !== m_irq) begin
        n_fail++;
        $display("FAIL rand_irq: iter %0d got %b need %b", i, irq, m_irq);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_rise_irq();
    test_both_fall();
    test_set_wins();
    test_regs();
    test_step_latency();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
